// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit retired per clock, signed or
// unsigned per operation, valid/ready handshakes on both sides.
module seq_multiplier #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     mplier_q;
   logic                 neg_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic [WIDTH-1:0]     mag_a_d;
   logic [WIDTH-1:0]     mag_b_d;
   logic [WIDTH:0]       sum_d;
   logic [WIDTH-1:0]     acc_d;
   logic [WIDTH-1:0]     mplier_d;
   logic [2*WIDTH-1:0]   result_d;

   // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exact as an unsigned value.
   always_comb begin
      mag_a_d  = (signed_mode && a[WIDTH-1]) ? -a : a;
      mag_b_d  = (signed_mode && b[WIDTH-1]) ? -b : b;
      sum_d    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      acc_d    = sum_d[WIDTH:1];
      mplier_d = {sum_d[0], mplier_q[WIDTH-1:1]};
      result_d = neg_q ? -{acc_d, mplier_d} : {acc_d, mplier_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q  <= mag_a_d;
                  mplier_q <= mag_b_d;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  busy_q   <= 1'b1;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               // The final step writes the product from the shifted value directly.
               if (cnt_q == LAST_STEP) begin
                  product_q   <= result_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a 4-bit and an 8-bit instance driven by
// directed and random operations, checked against an integer-arithmetic model.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic       iv4 = 1'b0, m4 = 1'b0, ordy4 = 1'b1;
   logic [3:0] a4 = '0, b4 = '0;
   logic       ir4, ov4, busy4;
   logic [7:0] prod4;

   logic       iv8 = 1'b0, m8 = 1'b0, ordy8 = 1'b1;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ir8, ov8, busy8;
   logic [15:0] prod8;

   logic [15:0] q4[$];
   logic [15:0] q8[$];
   logic        rand_done = 1'b0;

   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .signed_mode(m4), .out_valid(ov4), .out_ready(ordy4), .product(prod4), .busy(busy4)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(m8), .out_valid(ov8), .out_ready(ordy8), .product(prod8), .busy(busy8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out, got no event, expected one", nm);
   endtask

   // Reference: interpret operands as integers, multiply, keep 2*w bits.
   function automatic logic [15:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                         input logic sm);
      longint sx = longint'(x);
      longint sy = longint'(y);
      longint p;
      if (sm && x[w-1]) sx = sx - (longint'(1) << w);
      if (sm && y[w-1]) sy = sy - (longint'(1) << w);
      p = sx * sy;
      return 16'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   always @(negedge clk) begin
      if (rst_n && ov4 && ordy4) begin
         if (q4.size() == 0) chk("w4_unexpected_output", 32'(prod4), 32'hFFFF_FFFF);
         else chk("w4_product", 32'(prod4), 32'(q4.pop_front()));
      end
      if (rst_n && ov8 && ordy8) begin
         if (q8.size() == 0) chk("w8_unexpected_output", 32'(prod8), 32'hFFFF_FFFF);
         else chk("w8_product", 32'(prod8), 32'(q8.pop_front()));
      end
   end

   task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic im,
                         output int acc_cyc);
      int t = 0;
      @(negedge clk);
      while (!ir4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ir4) begin
         timeout("w4_in_ready");
         acc_cyc = cyc;
      end else begin
         a4 = ia; b4 = ib; m4 = im; iv4 = 1'b1;
         q4.push_back(model(4, {4'b0, ia}, {4'b0, ib}, im));
         @(posedge clk);
         #1;
         iv4 = 1'b0;
         acc_cyc = cyc;
      end
   endtask

   task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                         output int acc_cyc);
      int t = 0;
      @(negedge clk);
      while (!ir8 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ir8) begin
         timeout("w8_in_ready");
         acc_cyc = cyc;
      end else begin
         a8 = ia; b8 = ib; m8 = im; iv8 = 1'b1;
         q8.push_back(model(8, ia, ib, im));
         @(posedge clk);
         #1;
         iv8 = 1'b0;
         acc_cyc = cyc;
      end
   endtask

   task automatic wait_ov(input bit wide, output int seen_cyc);
      int t = 0;
      @(negedge clk);
      while (!(wide ? ov8 : ov4) && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (!(wide ? ov8 : ov4)) timeout(wide ? "w8_out_valid" : "w4_out_valid");
      seen_cyc = cyc;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((q4.size() != 0 || q8.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk(nm, 32'(q4.size() + q8.size()), 32'd0);
   endtask

   initial begin
      int acc, seen, prev;
      #2;
      chk("rst_in_ready4", 32'(ir4), 32'd1);
      chk("rst_out_valid4", 32'(ov4), 32'd0);
      chk("rst_product4", 32'(prod4), 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_product8", 32'(prod8), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue4(4'd15, 4'd15, 1'b0, acc);
      @(negedge clk);
      chk("busy_during_op", 32'(busy4), 32'd1);
      wait_ov(1'b0, seen);
      chk("w4_latency", 32'(seen - acc), 32'd4);

      issue4(4'b1000, 4'b1000, 1'b1, acc);
      issue4(4'b1000, 4'b0111, 1'b1, acc);
      issue4(4'b0011, 4'b1111, 1'b1, acc);
      drain("drain_signed");

      // Output backpressure with ignored input pulses.
      @(posedge clk);
      #1;
      ordy4 = 1'b0;
      issue4(4'd5, 4'd6, 1'b0, acc);
      wait_ov(1'b0, seen);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(ov4), 32'd1);
         chk("hold_product", 32'(prod4), 32'd30);
         chk("hold_in_ready", 32'(ir4), 32'd0);
         iv4 = 1'b1;
         a4 = 4'($urandom);
         b4 = 4'($urandom);
      end
      @(posedge clk);
      #1;
      iv4 = 1'b0;
      ordy4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", 32'(ir4), 32'd1);
      chk("release_out_valid", 32'(ov4), 32'd0);
      drain("drain_backpressure");

      // Reset two steps into an operation.
      issue4(4'd9, 4'd13, 1'b0, acc);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q4.delete();
      #1;
      chk("abort_out_valid", 32'(ov4), 32'd0);
      chk("abort_product", 32'(prod4), 32'd0);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_in_ready", 32'(ir4), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue4(4'd9, 4'd13, 1'b0, acc);
      drain("drain_after_reset");

      // Exhaustive 4-bit sweep, back to back.
      prev = -1;
      for (int m = 0; m < 2; m++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
               issue4(4'(x), 4'(y), 1'(m), acc);
               if (prev >= 0) chk("issue_interval", 32'(acc - prev), 32'd6);
               prev = acc;
            end
      drain("drain_sweep");

      // 8-bit random with output stalls.
      fork
         begin
            for (int i = 0; i < 1000; i++)
               issue8(8'($urandom), 8'($urandom), 1'($urandom), acc);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               ordy8 = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            ordy8 = 1'b1;
         end
      join
      drain("drain_random");

      issue8(8'h00, 8'hFF, 1'b0, acc);
      wait_ov(1'b1, seen);
      chk("w8_zero_latency", 32'(seen - acc), 32'd8);
      chk("w8_zero_product", 32'(prod8), 32'd0);
      drain("drain_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
